hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 104 ++++++++++
 tb/tb_hazard_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard detection for the decode stage: operand forwarding select,
// Tnew/Tuse stall, multiply/divide busy window and a stall cycle counter.
module hazard_unit #(
    parameter int NSTAGE   = 3,
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int SW       = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [AW-1:0]        id_a1,
    input  logic [AW-1:0]        id_a2,
    input  logic [TW-1:0]        id_tuse1,
    input  logic [TW-1:0]        id_tuse2,
    input  logic [NSTAGE*AW-1:0] prod_a3,
    input  logic [NSTAGE-1:0]    prod_we,
    input  logic [NSTAGE*TW-1:0] prod_tnew,
    input  logic                 mdu_start,
    input  logic                 mdu_is_div,
    input  logic                 mdu_cancel,
    input  logic                 id_mdu_req,
    input  logic                 cnt_clr,
    output logic                 stall,
    output logic [SW-1:0]        fwd_sel1,
    output logic [SW-1:0]        fwd_sel2,
    output logic                 mdu_busy,
    output logic [31:0]          stall_cnt
);

    localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW     = $clog2(MAXLAT + 1);

    logic [AW-1:0] w_src  [2];
    logic [TW-1:0] w_tuse [2];
    logic [TW-1:0] w_tnew [2];
    logic [SW-1:0] w_idx  [2];
    logic [SW-1:0] w_sel  [2];
    logic [1:0]    w_hit;
    logic [1:0]    w_haz;
    logic          w_mdu_stall;

    logic [CW-1:0] r_mdu_cnt;
    logic [31:0]   r_stall_cnt;

    assign w_src[0]  = id_a1;
    assign w_src[1]  = id_a2;
    assign w_tuse[0] = id_tuse1;
    assign w_tuse[1] = id_tuse2;

    // Per operand: nearest matching producer decides hazard and forward path
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_hit[n]  = 1'b0;
            w_idx[n]  = '0;
            w_tnew[n] = '0;
            for (int i = NSTAGE - 1; i >= 0; i--) begin
                if (prod_we[i] && (prod_a3[i*AW +: AW] == w_src[n])) begin
                    w_hit[n]  = 1'b1;
                    w_idx[n]  = SW'(i);
                    w_tnew[n] = prod_tnew[i*TW +: TW];
                end
            end
            if (w_src[n] == '0) begin
                w_hit[n] = 1'b0;
            end
            w_haz[n] = w_hit[n] && (w_tnew[n] > w_tuse[n]);
            w_sel[n] = (w_hit[n] && (w_tnew[n] == '0)) ? (w_idx[n] + SW'(1)) : '0;
        end
    end

    assign fwd_sel1    = w_sel[0];
    assign fwd_sel2    = w_sel[1];
    assign mdu_busy    = (r_mdu_cnt != '0);
    assign w_mdu_stall = id_mdu_req & (mdu_busy | mdu_start);
    assign stall       = w_haz[0] | w_haz[1] | w_mdu_stall;
    assign stall_cnt   = r_stall_cnt;

    // MDU busy countdown: cancel beats start, start beats decrement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mdu_cnt <= '0;
        end else if (mdu_cancel) begin
            r_mdu_cnt <= '0;
        end else if (mdu_start) begin
            r_mdu_cnt <= mdu_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (r_mdu_cnt != '0) begin
            r_mdu_cnt <= r_mdu_cnt - CW'(1);
        end
    end

    // Saturating count of stalled cycles, clear has priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, directed
// multi-cycle sequences and a randomized run against a reference model.
module tb_hazard_unit;

    logic        clk;
    logic        reset_n;
    logic [4:0]  id_a1, id_a2;
    logic [1:0]  id_tuse1, id_tuse2;
    logic [14:0] prod_a3;
    logic [2:0]  prod_we;
    logic [5:0]  prod_tnew;
    logic        mdu_start, mdu_is_div, mdu_cancel, id_mdu_req, cnt_clr;
    logic        stall;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic        mdu_busy;
    logic [31:0] stall_cnt;

    logic [19:0] a3_4;
    logic [3:0]  we_4;
    logic [7:0]  tnew_4;
    logic        stall_4;
    logic [2:0]  sel1_4, sel2_4;
    logic        busy_4;
    logic [31:0] cnt_4;

    int n_pass;
    int n_total;

    hazard_unit dut (
        .clk(clk), .reset_n(reset_n),
        .id_a1(id_a1), .id_a2(id_a2),
        .id_tuse1(id_tuse1), .id_tuse2(id_tuse2),
        .prod_a3(prod_a3), .prod_we(prod_we), .prod_tnew(prod_tnew),
        .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
        .mdu_cancel(mdu_cancel), .id_mdu_req(id_mdu_req),
        .cnt_clr(cnt_clr), .stall(stall),
        .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    hazard_unit #(.NSTAGE(4)) u4 (
        .clk(clk), .reset_n(reset_n),
        .id_a1(id_a1), .id_a2(id_a2),
        .id_tuse1(id_tuse1), .id_tuse2(id_tuse2),
        .prod_a3(a3_4), .prod_we(we_4), .prod_tnew(tnew_4),
        .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
        .mdu_cancel(mdu_cancel), .id_mdu_req(id_mdu_req),
        .cnt_clr(cnt_clr), .stall(stall_4),
        .fwd_sel1(sel1_4), .fwd_sel2(sel2_4),
        .mdu_busy(busy_4), .stall_cnt(cnt_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [1:0]  t1;
        logic [1:0]  t2;
        logic [14:0] a3;
        logic [2:0]  we;
        logic [5:0]  tn;
        logic        st;
        logic [1:0]  s1;
        logic [1:0]  s2;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        id_a1 = 0; id_a2 = 0; id_tuse1 = 0; id_tuse2 = 0;
        prod_a3 = 0; prod_we = 0; prod_tnew = 0;
        a3_4 = 0; we_4 = 0; tnew_4 = 0;
        mdu_start = 0; mdu_is_div = 0; mdu_cancel = 0;
        id_mdu_req = 0; cnt_clr = 0;
    endtask

    // Spec-level operand rule: first writing stage in order 0..N-1 wins
    function automatic void ref_op(
        input logic [4:0] a, input logic [1:0] tu,
        input logic [14:0] a3, input logic [2:0] we, input logic [5:0] tn,
        output logic hz, output logic [1:0] sel);
        hz = 1'b0;
        sel = 2'd0;
        if (a != 5'd0) begin
            for (int i = 0; i < 3; i++) begin
                if (we[i] && a3[i*5 +: 5] == a) begin
                    hz = (tn[i*2 +: 2] > tu);
                    sel = (tn[i*2 +: 2] == 2'd0) ? 2'(i + 1) : 2'd0;
                    break;
                end
            end
        end
    endfunction

    initial begin
        logic        h1, h2, e_st, e_busy;
        logic [1:0]  e1, e2;
        int          rem;
        longint      scnt;
        int          bc;

        n_pass = 0;
        n_total = 0;
        clr_in();
        reset_n = 1'b0;

        tbl[0] = '{5'd8, 5'd0, 2'd0, 2'd0, 15'd8,    3'b001, 6'b000001, 1'b1, 2'd0, 2'd0};
        tbl[1] = '{5'd8, 5'd0, 2'd0, 2'd0, 15'd256,  3'b010, 6'b000000, 1'b0, 2'd2, 2'd0};
        tbl[2] = '{5'd0, 5'd9, 2'd0, 2'd0, 15'd9225, 3'b101, 6'b000000, 1'b0, 2'd0, 2'd1};
        tbl[3] = '{5'd0, 5'd0, 2'd0, 2'd0, 15'd0,    3'b111, 6'b111111, 1'b0, 2'd0, 2'd0};
        tbl[4] = '{5'd5, 5'd0, 2'd2, 2'd0, 15'd5120, 3'b100, 6'b100000, 1'b0, 2'd0, 2'd0};
        tbl[5] = '{5'd5, 5'd0, 2'd2, 2'd0, 15'd5120, 3'b100, 6'b110000, 1'b1, 2'd0, 2'd0};
        tbl[6] = '{5'd7, 5'd0, 2'd0, 2'd0, 15'd231,  3'b011, 6'b000001, 1'b1, 2'd0, 2'd0};
        tbl[7] = '{5'd7, 5'd0, 2'd0, 2'd0, 15'd231,  3'b010, 6'b000001, 1'b0, 2'd2, 2'd0};
        tbl[8] = '{5'd3, 5'd4, 2'd0, 2'd0, 15'd4192, 3'b110, 6'b000000, 1'b0, 2'd2, 2'd3};

        #12;
        chk("reset_busy", 32'(mdu_busy), 32'd0);
        chk("reset_cnt", stall_cnt, 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        #1 reset_n = 1'b1;

        // Vector table, MDU idle
        for (int k = 0; k < 9; k++) begin
            cyc();
            id_a1 = tbl[k].a1; id_a2 = tbl[k].a2;
            id_tuse1 = tbl[k].t1; id_tuse2 = tbl[k].t2;
            prod_a3 = tbl[k].a3; prod_we = tbl[k].we; prod_tnew = tbl[k].tn;
            #1;
            chk($sformatf("vec%0d_stall", k), 32'(stall), 32'(tbl[k].st));
            chk($sformatf("vec%0d_sel1", k), 32'(fwd_sel1), 32'(tbl[k].s1));
            chk($sformatf("vec%0d_sel2", k), 32'(fwd_sel2), 32'(tbl[k].s2));
        end

        // Four-stage build: stage 3 forwarding and nearest-stage priority
        cyc(); clr_in();
        id_a1 = 5'd8; a3_4 = 20'(8) << 15; we_4 = 4'b1000;
        #1;
        chk("n4_sel1_stage3", 32'(sel1_4), 32'd4);
        chk("n4_stall0", 32'(stall_4), 32'd0);
        tnew_4 = 8'b0100_0000;
        #1;
        chk("n4_stall_stage3", 32'(stall_4), 32'd1);
        chk("n4_sel1_busy", 32'(sel1_4), 32'd0);
        cyc(); clr_in();
        id_a2 = 5'd9; a3_4 = (20'(9) << 15) | 20'd9; we_4 = 4'b1001;
        #1;
        chk("n4_sel2_prio", 32'(sel2_4), 32'd1);
        id_a2 = 5'd0; a3_4 = 20'd0; we_4 = 4'b1111; tnew_4 = 8'hFF;
        #1;
        chk("n4_zero_sel2", 32'(sel2_4), 32'd0);
        chk("n4_zero_stall", 32'(stall_4), 32'd0);

        // Divide: stall cycle 0 through 10, busy exactly 10 cycles
        cyc(); clr_in();
        mdu_start = 1; mdu_is_div = 1; id_mdu_req = 1;
        #1;
        chk("div_c0_stall", 32'(stall), 32'd1);
        chk("div_c0_busy", 32'(mdu_busy), 32'd0);
        bc = 0;
        for (int k = 1; k <= 11; k++) begin
            cyc();
            mdu_start = 0;
            #1;
            if (mdu_busy) bc++;
            chk($sformatf("div_c%0d_stall", k), 32'(stall), (k <= 10) ? 32'd1 : 32'd0);
        end
        chk("div_busy_cycles", bc, 32'd10);

        // Multiply cancelled at count 3
        cyc(); clr_in();
        mdu_start = 1;
        cyc(); mdu_start = 0;
        cyc();
        cyc();
        mdu_cancel = 1;
        #1;
        chk("cancel_busy_before", 32'(mdu_busy), 32'd1);
        cyc(); mdu_cancel = 0;
        #1;
        chk("cancel_busy_after", 32'(mdu_busy), 32'd0);

        // Restart at count 2 reloads full multiply latency
        cyc(); mdu_start = 1;
        cyc(); mdu_start = 0;
        cyc(); cyc(); cyc();
        mdu_start = 1;
        cyc(); mdu_start = 0;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk($sformatf("restart_busy%0d", j), 32'(mdu_busy), 32'd1);
            cyc();
        end
        #1;
        chk("restart_idle", 32'(mdu_busy), 32'd0);

        // Stall counter: 7 stalls, clear priority, saturation
        cyc(); clr_in(); cnt_clr = 1;
        cyc(); cnt_clr = 0;
        id_a1 = 5'd8; prod_a3 = 15'd8; prod_we = 3'b001; prod_tnew = 6'b000001;
        repeat (7) cyc();
        clr_in();
        #1;
        chk("cnt_seven", stall_cnt, 32'd7);
        id_a1 = 5'd8; prod_a3 = 15'd8; prod_we = 3'b001; prod_tnew = 6'b000001;
        cnt_clr = 1;
        cyc(); clr_in();
        #1;
        chk("cnt_clr_prio", stall_cnt, 32'd0);
        force dut.r_stall_cnt = 32'hFFFF_FFFD;
        #1 release dut.r_stall_cnt;
        id_a1 = 5'd8; prod_a3 = 15'd8; prod_we = 3'b001; prod_tnew = 6'b000001;
        repeat (5) cyc();
        clr_in();
        #1;
        chk("cnt_saturate", stall_cnt, 32'hFFFF_FFFF);

        // Asynchronous reset in the middle of a divide
        cyc(); clr_in();
        mdu_start = 1; mdu_is_div = 1; id_mdu_req = 1;
        cyc(); mdu_start = 0;
        repeat (4) cyc();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_busy_async", 32'(mdu_busy), 32'd0);
        chk("rst_cnt_async", stall_cnt, 32'd0);
        chk("rst_stall_idle", 32'(stall), 32'd0);
        mdu_start = 1;
        #1;
        chk("rst_stall_start", 32'(stall), 32'd1);
        clr_in();
        id_a1 = 5'd8; prod_a3 = 15'd256; prod_we = 3'b010;
        #1;
        chk("rst_fwd", 32'(fwd_sel1), 32'd2);
        clr_in();
        #1 reset_n = 1'b1;
        cyc();
        #1;
        chk("rst_after_busy", 32'(mdu_busy), 32'd0);

        // Randomized run against the reference model
        rem = 0;
        scnt = 0;
        for (int k = 0; k < 400; k++) begin
            cyc();
            id_a1 = 5'($urandom_range(0, 3));
            id_a2 = 5'($urandom_range(0, 3));
            id_tuse1 = 2'($urandom);
            id_tuse2 = 2'($urandom);
            prod_a3 = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3))};
            prod_we = 3'($urandom);
            prod_tnew = 6'($urandom);
            mdu_start = ($urandom_range(0, 7) == 0);
            mdu_is_div = 1'($urandom);
            mdu_cancel = ($urandom_range(0, 15) == 0);
            id_mdu_req = 1'($urandom);
            cnt_clr = ($urandom_range(0, 19) == 0);
            #1;
            ref_op(id_a1, id_tuse1, prod_a3, prod_we, prod_tnew, h1, e1);
            ref_op(id_a2, id_tuse2, prod_a3, prod_we, prod_tnew, h2, e2);
            e_busy = (rem != 0);
            e_st = h1 | h2 | (id_mdu_req & (e_busy | mdu_start));
            chk("rnd_stall", 32'(stall), 32'(e_st));
            chk("rnd_sel1", 32'(fwd_sel1), 32'(e1));
            chk("rnd_sel2", 32'(fwd_sel2), 32'(e2));
            chk("rnd_busy", 32'(mdu_busy), 32'(e_busy));
            chk("rnd_cnt", stall_cnt, 32'(scnt));
            if (cnt_clr) scnt = 0;
            else if (e_st && scnt < 64'hFFFF_FFFF) scnt = scnt + 1;
            if (mdu_cancel) rem = 0;
            else if (mdu_start) rem = mdu_is_div ? 10 : 5;
            else if (rem > 0) rem = rem - 1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
